// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM state encoding,
// byte width and the default write-acceptance timeout.
package uart_pkg;

   localparam int UART_DW             = 8;
   localparam int ACC_TIMEOUT_DEFAULT = 16;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WRITE    = 2'd1,
      WAIT_ACC = 2'd2,
      WAIT_RDY = 2'd3
   } sched_state_t;

endpackage

// File: rtl/uart_rr_arb.sv
// Combinational round-robin picker: the first set req bit searching upward
// from last_gnt+1 with wrap-around wins.
module uart_rr_arb
   import uart_pkg::*;
#(
   parameter  int NREQ = 4,
   localparam int IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   last_gnt,
   output logic [NREQ-1:0] win_oh,
   output logic [IW-1:0]   win_idx,
   output logic            any
);

   logic [IW-1:0] idx;

   // Walk offsets from farthest to nearest so the nearest requester overwrites.
   always_comb begin
      win_oh  = '0;
      win_idx = '0;
      any     = 1'b0;
      idx     = '0;
      for (int k = NREQ; k >= 1; k--) begin
         idx = IW'((int'(last_gnt) + k) % NREQ);
         if (req[idx]) begin
            win_oh      = '0;
            win_oh[idx] = 1'b1;
            win_idx     = idx;
            any         = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart_tx among NREQ byte sources.
// Optional acceptance timeout: define UART_TX_SCHED_TIMEOUT_EN.
module uart_tx_sched
   import uart_pkg::*;
#(
   parameter  int NREQ        = 4,
   parameter  int ACC_TIMEOUT = ACC_TIMEOUT_DEFAULT,
   localparam int IW          = $clog2(NREQ)
) (
   input  logic                    mclkx16,
   input  logic                    reset,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*UART_DW-1:0] req_data,
   output logic [NREQ-1:0]         gnt,
   output logic                    tx_write,
   output logic [UART_DW-1:0]      tx_data,
   input  logic                    tx_rdy,
   output logic                    busy,
   output logic [IW-1:0]           last_gnt,
   output logic                    timeout_err
);

   sched_state_t       state, state_nxt;
   logic [NREQ-1:0]    win_oh;
   logic [IW-1:0]      win_idx;
   logic               any;
   logic               take;
   logic               acc_expired;
   logic [UART_DW-1:0] win_byte;

   uart_rr_arb #(.NREQ(NREQ)) u_arb (
      .req      (req),
      .last_gnt (last_gnt),
      .win_oh   (win_oh),
      .win_idx  (win_idx),
      .any      (any)
   );

   always_comb begin
      win_byte = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win_oh[i]) win_byte = req_data[UART_DW*i +: UART_DW];
      end
   end

`ifdef UART_TX_SCHED_TIMEOUT_EN
   localparam int CW = $clog2(ACC_TIMEOUT + 1);
   logic [CW-1:0] acc_cnt;

   assign acc_expired = (state == WAIT_ACC) && tx_rdy && (acc_cnt == CW'(ACC_TIMEOUT - 1));

   // Counter restarts on every entry to WAIT_ACC; the error flag is sticky until reset.
   always_ff @(posedge mclkx16) begin
      if (!reset) begin
         acc_cnt     <= '0;
         timeout_err <= 1'b0;
      end else begin
         if (state != WAIT_ACC) acc_cnt <= '0;
         else if (tx_rdy)       acc_cnt <= acc_cnt + 1'b1;
         if (acc_expired) timeout_err <= 1'b1;
      end
   end
`else
   logic unused_acc_timeout;
   assign unused_acc_timeout = (ACC_TIMEOUT != 0);
   assign acc_expired        = 1'b0;
   assign timeout_err        = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      take      = 1'b0;
      case (state)
         IDLE: begin
            if (tx_rdy && any) begin
               state_nxt = WRITE;
               take      = 1'b1;
            end
         end
         WRITE:    state_nxt = WAIT_ACC;
         WAIT_ACC: begin
            if (!tx_rdy)          state_nxt = WAIT_RDY;
            else if (acc_expired) state_nxt = IDLE;
         end
         WAIT_RDY: if (tx_rdy) state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   // gnt/tx_write are loaded only on the arbitration edge, so they are one-cycle pulses.
   always_ff @(posedge mclkx16) begin
      if (!reset) begin
         state    <= IDLE;
         gnt      <= '0;
         tx_write <= 1'b0;
         tx_data  <= '0;
         last_gnt <= IW'(NREQ - 1);
      end else begin
         state    <= state_nxt;
         gnt      <= take ? win_oh : '0;
         tx_write <= take;
         if (take) begin
            tx_data  <= win_byte;
            last_gnt <= win_idx;
         end
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: reset, table-driven arbitration,
// corner-case sequences and randomized traffic against a round-robin model.
module tb_uart_tx_sched;

   localparam int NREQ = 4;

   logic        mclkx16 = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  req = '0;
   logic [31:0] req_data = '0;
   logic [3:0]  gnt;
   logic        tx_write;
   logic [7:0]  tx_data;
   logic        tx_rdy = 1'b1;
   logic        busy;
   logic [1:0]  last_gnt;
   logic        timeout_err;

   always #5 mclkx16 = ~mclkx16;

   uart_tx_sched #(.NREQ(NREQ), .ACC_TIMEOUT(16)) dut (
      .mclkx16     (mclkx16),
      .reset       (reset),
      .req         (req),
      .req_data    (req_data),
      .gnt         (gnt),
      .tx_write    (tx_write),
      .tx_data     (tx_data),
      .tx_rdy      (tx_rdy),
      .busy        (busy),
      .last_gnt    (last_gnt),
      .timeout_err (timeout_err)
   );

   int checks = 0;
   int errors = 0;

   // uart_tx behavioural model: tx_rdy drops drop_dly cycles after a write
   // and stays low for low_len cycles.
   bit auto_rdy = 1'b1;
   int drop_dly = 2, low_len = 176;
   int drop_cnt = 0, low_cnt = 0;
   int cyc = 0, rdy_rise_cyc = -1, n_writes = 0;

   // Reference model state: index of the most recent grant.
   int m_last = 3;

   typedef struct {
      logic [3:0]  r;
      logic [31:0] d;
      bit          hold;
      int          exp_idx;
      logic [7:0]  exp_byte;
   } vec_t;

   vec_t vecs[12];

   function automatic int rr_pick(logic [3:0] r, int last);
      for (int k = 1; k <= NREQ; k++) begin
         if (r[(last + k) % NREQ]) return (last + k) % NREQ;
      end
      return -1;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge mclkx16);
      #1;
      cyc++;
      if (tx_write === 1'b1) n_writes++;
      if (auto_rdy) begin
         if (tx_write === 1'b1) drop_cnt = drop_dly;
         else if (drop_cnt > 0) begin
            drop_cnt--;
            if (drop_cnt == 0) begin
               tx_rdy  = 1'b0;
               low_cnt = low_len;
            end
         end else if (low_cnt > 0) begin
            low_cnt--;
            if (low_cnt == 0) begin
               tx_rdy       = 1'b1;
               rdy_rise_cyc = cyc;
            end
         end
      end
   endtask

   task automatic model_idle();
      auto_rdy = 1'b0;
      drop_cnt = 0;
      low_cnt  = 0;
      tx_rdy   = 1'b1;
      auto_rdy = 1'b1;
   endtask

   // One complete transfer: request in IDLE, check the grant, then follow it to IDLE.
   task automatic xfer(string tag, logic [3:0] r, logic [31:0] d, int w, logic [7:0] eb,
                       bit hold, bit garble, int dd, int ll);
      int  wr0, bud;
      bit  data_bad, pulse_bad;
      drop_dly  = dd;
      low_len   = ll;
      req       = r;
      req_data  = d;
      wr0       = n_writes;
      data_bad  = 1'b0;
      pulse_bad = 1'b0;
      step();
      chk({tag, "_write"}, 32'(tx_write), 32'd1);
      chk({tag, "_gnt"}, 32'(gnt), 32'd1 << w);
      chk({tag, "_data"}, 32'(tx_data), 32'(eb));
      chk({tag, "_last"}, 32'(last_gnt), 32'(w));
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      m_last = w;
      if (!hold) req = '0;
      bud = 0;
      while (busy === 1'b1 && bud < 2000) begin
         if (garble) req = 4'($urandom);
         step();
         bud++;
         if (tx_data !== eb) data_bad = 1'b1;
         if (gnt !== 4'b0 || tx_write !== 1'b0) pulse_bad = 1'b1;
      end
      chk({tag, "_idle"}, 32'(busy), 32'd0);
      chk({tag, "_nwrites"}, 32'(n_writes - wr0), 32'd1);
      chk({tag, "_held"}, 32'(data_bad), 32'd0);
      chk({tag, "_pulse"}, 32'(pulse_bad), 32'd0);
      chk({tag, "_busyfall"}, 32'(cyc - rdy_rise_cyc), 32'd1);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   initial begin
      bit bad;
      logic [3:0] r;
      logic [31:0] d;
      int w;

      vecs[0]  = '{4'b1111, 32'h13121110, 1'b1, 0, 8'h10};
      vecs[1]  = '{4'b1111, 32'h13121110, 1'b1, 1, 8'h11};
      vecs[2]  = '{4'b1111, 32'h13121110, 1'b1, 2, 8'h12};
      vecs[3]  = '{4'b1111, 32'h13121110, 1'b1, 3, 8'h13};
      vecs[4]  = '{4'b1111, 32'h13121110, 1'b1, 0, 8'h10};
      vecs[5]  = '{4'b0110, 32'h13121110, 1'b0, 1, 8'h11};
      vecs[6]  = '{4'b1001, 32'h13121110, 1'b0, 3, 8'h13};
      vecs[7]  = '{4'b0011, 32'h13121110, 1'b0, 0, 8'h10};
      vecs[8]  = '{4'b1000, 32'hDE000000, 1'b0, 3, 8'hDE};
      vecs[9]  = '{4'b0101, 32'h00330044, 1'b0, 0, 8'h44};
      vecs[10] = '{4'b0101, 32'h00330044, 1'b0, 2, 8'h33};
      vecs[11] = '{4'b0010, 32'h00007700, 1'b0, 1, 8'h77};

      // Reset held with all requesters pending.
      reset = 1'b0;
      req   = 4'b1111;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_gnt", 32'(gnt), 32'd0);
         chk("rst_write", 32'(tx_write), 32'd0);
         chk("rst_busy", 32'(busy), 32'd0);
         chk("rst_last", 32'(last_gnt), 32'd3);
      end
      chk("rst_data", 32'(tx_data), 32'h00);
      chk("rst_terr", 32'(timeout_err), 32'd0);
      reset = 1'b1;

      // Fairness and table-driven arbitration.
      for (int i = 0; i < 12; i++) begin
         xfer($sformatf("vec%0d", i), vecs[i].r, vecs[i].d, vecs[i].exp_idx,
              vecs[i].exp_byte, vecs[i].hold, 1'b0, 1 + (i % 3), 3 + i);
      end

      // Single requester after a fresh reset, slow uart_tx.
      reset = 1'b0;
      req   = '0;
      step();
      model_idle();
      reset  = 1'b1;
      m_last = 3;
      xfer("single", 4'b0100, 32'h00A50000, 2, 8'hA5, 1'b0, 1'b0, 2, 176);

      // Transmitter not ready in IDLE: no grant until tx_rdy returns.
      auto_rdy = 1'b0;
      tx_rdy   = 1'b0;
      req      = 4'b0001;
      req_data = 32'h000000C3;
      bad      = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (gnt !== 4'b0 || tx_write !== 1'b0 || busy !== 1'b0) bad = 1'b1;
      end
      chk("notrdy_hold", 32'(bad), 32'd0);
      auto_rdy = 1'b1;
      tx_rdy   = 1'b1;
      xfer("notrdy", 4'b0001, 32'h000000C3, 0, 8'hC3, 1'b0, 1'b0, 2, 5);

      // Reset while in WAIT_RDY abandons the byte; requester 0 wins afterwards.
      drop_dly = 2;
      low_len  = 50;
      req      = 4'b0100;
      req_data = 32'h00EE0000;
      step();
      chk("midrst_write", 32'(tx_write), 32'd1);
      req = '0;
      for (int i = 0; i < 10 && tx_rdy !== 1'b0; i++) step();
      step();
      chk("midrst_pre_busy", 32'(busy), 32'd1);
      reset = 1'b0;
      req   = 4'b1111;
      req_data = 32'h13121110;
      step();
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_gnt", 32'(gnt), 32'd0);
      chk("midrst_write0", 32'(tx_write), 32'd0);
      chk("midrst_last", 32'(last_gnt), 32'd3);
      model_idle();
      step();
      chk("midrst_gnt2", 32'(gnt), 32'd0);
      reset  = 1'b1;
      m_last = 3;
      xfer("midrst_after", 4'b1111, 32'h13121110, 0, 8'h10, 1'b0, 1'b0, 1, 4);

      // Randomized traffic against the round-robin model.
      for (int t = 0; t < 60; t++) begin
         r = 4'($urandom_range(0, 15));
         d = $urandom;
         if (r == 4'b0) begin
            req = '0;
            step();
            chk("rnd_none_write", 32'(tx_write), 32'd0);
            chk("rnd_none_busy", 32'(busy), 32'd0);
         end else begin
            w = rr_pick(r, m_last);
            xfer($sformatf("rnd%0d", t), r, d, w, d[8*w +: 8], 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), int'($urandom_range(1, 4)),
                 int'($urandom_range(1, 20)));
         end
      end

      // Write never accepted: tx_rdy stuck high.
      req      = '0;
      auto_rdy = 1'b0;
      tx_rdy   = 1'b1;
      req      = 4'b0001;
      req_data = 32'h0000005A;
      step();
      chk("to_write", 32'(tx_write), 32'd1);
      req = '0;
      step();
`ifdef UART_TX_SCHED_TIMEOUT_EN
      bad = 1'b0;
      for (int i = 0; i < 15; i++) begin
         step();
         if (busy !== 1'b1 || timeout_err !== 1'b0) bad = 1'b1;
      end
      chk("to_early", 32'(bad), 32'd0);
      step();
      chk("to_idle", 32'(busy), 32'd0);
      chk("to_err", 32'(timeout_err), 32'd1);
      bad = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (timeout_err !== 1'b1 || tx_write !== 1'b0) bad = 1'b1;
      end
      chk("to_sticky", 32'(bad), 32'd0);
      reset = 1'b0;
      step();
      chk("to_clear", 32'(timeout_err), 32'd0);
      reset = 1'b1;
`else
      bad = 1'b0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (busy !== 1'b1 || timeout_err !== 1'b0) bad = 1'b1;
      end
      chk("noto_wait", 32'(bad), 32'd0);
      tx_rdy = 1'b0;
      step();
      tx_rdy = 1'b1;
      step();
      chk("noto_idle", 32'(busy), 32'd0);
      chk("noto_err", 32'(timeout_err), 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
